// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state enum and counter sizing.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 step: shift-add for multiply, restoring
// shift-subtract for divide (remainder upper half, quotient lower half).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mag,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag};
    // Partial remainder shifted left, pulling in the next dividend bit.
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, mag};
    acc_next = '0;
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply/divide writing HI/LO; WIDTH+2 cycle
// latency, one op per WIDTH+3 cycles, cancellable by flush.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  muldiv_state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mag_q;
  logic               is_div_q;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic               dz_q;

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               b_zero;
  logic               accept;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;
  logic [2*WIDTH-1:0] acc_neg;

  always_comb begin
    is_signed = !op[0];
    a_neg     = is_signed && a[WIDTH-1];
    b_neg     = is_signed && b[WIDTH-1];
    // The most-negative value maps onto itself, which read unsigned is
    // exactly its magnitude.
    mag_a     = a_neg ? (~a + 1'b1) : a;
    mag_b     = b_neg ? (~b + 1'b1) : b;
    b_zero    = (b == '0);
    accept    = (state_q == S_IDLE) && start && !flush;
    hi_fix    = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    lo_fix    = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    acc_neg   = ~acc_q + 1'b1;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .mag      (mag_q),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (op[1] && b_zero) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      // Stays high through the done cycle; drops there unless a new op starts.
      busy     <= !flush && ((state_q != S_IDLE) || start);
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            acc_q    <= {{WIDTH{1'b0}}, mag_a};
            mag_q    <= mag_b;
            is_div_q <= op[1];
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= op[1] ? a_neg : (a_neg ^ b_neg);
            dz_q     <= op[1] && b_zero;
            cnt_q    <= '0;
          end
        end
        S_CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
        end
        S_FIX: begin
          if (is_div_q) begin
            acc_q <= {hi_fix, lo_fix};
          end else if (neg_lo_q) begin
            acc_q <= acc_neg;
          end
        end
        S_DONE: begin
          if (!flush) begin
            done <= 1'b1;
            if (dz_q) begin
              div_zero <= 1'b1;
            end else begin
              hi <= acc_q[2*WIDTH-1:WIDTH];
              lo <= acc_q[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at WIDTH=32: arithmetic, latency, div-by-zero,
// flush, reset and back-to-back throughput against hand-computed values.
module tb_muldiv_iter;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic         flush;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int passed;
  int total;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .flush    (flush),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present an op for one sampling edge (edge N), then scramble the operands.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Edges after edge N until done is visible; 999 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    if (!done) lat = 999;
  endtask

  int  lat;
  int  gap;
  bit  saw_done;

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    flush  = 1'b0;
    a      = '0;
    b      = '0;
    tick();
    tick();
    check("reset_outputs", {busy, done, div_zero, hi, lo[W-4:0]}, 64'd0);
    reset = 1'b1;
    tick();

    // MULT -1 * 7
    launch(2'b00, 32'hFFFFFFFF, 32'd7);
    check("mult_busy_start", {63'd0, busy}, 64'd1);
    wait_done(lat);
    check("mult_latency", 64'(lat), 64'd34);
    check("mult_busy_done", {63'd0, busy}, 64'd1);
    check("mult_result", {hi, lo}, 64'hFFFFFFFF_FFFFFFF9);
    tick();
    check("done_pulse_width", {62'd0, done, busy}, 64'd0);

    launch(2'b01, 32'hFFFFFFFF, 32'd7);
    wait_done(lat);
    check("multu_result", {hi, lo}, 64'h00000006_FFFFFFF9);
    tick();

    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(lat);
    check("div_signed_result", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    tick();

    launch(2'b11, 32'd7, 32'd2);
    wait_done(lat);
    check("divu_result", {hi, lo}, 64'h00000001_00000003);
    tick();

    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    check("div_overflow_result", {hi, lo}, 64'h00000000_80000000);
    check("div_overflow_flag", {63'd0, div_zero}, 64'd0);
    tick();

    // Preload then divide by zero: HI/LO must hold.
    launch(2'b01, 32'd3, 32'd5);
    wait_done(lat);
    check("preload_result", {hi, lo}, 64'h00000000_0000000F);
    tick();
    launch(2'b10, 32'd9, 32'd0);
    check("divzero_busy", {63'd0, busy}, 64'd1);
    wait_done(lat);
    check("divzero_latency", 64'(lat), 64'd1);
    check("divzero_flags", {62'd0, done, div_zero}, 64'd3);
    check("divzero_hold", {hi, lo}, 64'h00000000_0000000F);
    tick();
    check("divzero_pulse_end", {62'd0, done, div_zero}, 64'd0);

    // Ignored start mid-op, then flush.
    launch(2'b00, 32'd100, 32'd100);
    tick();
    tick();
    start = 1'b1;
    op    = 2'b11;
    b     = '0;
    tick();
    start = 1'b0;
    for (int i = 4; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_done", {62'd0, busy, done}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (done || div_zero) saw_done = 1'b1;
      tick();
    end
    check("flush_no_done", {63'd0, saw_done}, 64'd0);
    check("flush_hold", {hi, lo}, 64'h00000000_0000000F);
    launch(2'b01, 32'd2, 32'd2);
    wait_done(lat);
    check("after_flush_result", {hi, lo}, 64'h00000000_00000004);
    tick();

    // Reset mid-op.
    launch(2'b01, 32'd9, 32'd9);
    for (int i = 1; i < 20; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midop_reset", {busy, done, div_zero, hi, lo[W-4:0]}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("reset_no_done", {63'd0, saw_done}, 64'd0);

    // Back-to-back with start held high.
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd3;
    b     = 32'd4;
    tick();
    wait_done(lat);
    check("b2b_first_latency", 64'(lat), 64'd34);
    gap = 0;
    tick();
    gap++;
    check("b2b_busy_kept", {63'd0, busy}, 64'd1);
    while (!done && gap < 100) begin
      tick();
      gap++;
    end
    start = 1'b0;
    check("b2b_gap", 64'(gap), 64'd35);
    check("b2b_result", {hi, lo}, 64'h00000000_0000000C);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
